// File: rtl/vga_timing_gen.sv
// VGA sync/timing generator with two selectable timing sets.
// Registered state is the pixel position, frame count and active mode; every
// other output is a combinational decode of that state, so sync/blank/strobe
// outputs line up with hpos/vpos with no extra latency. The requested mode is
// only adopted on the last pixel of a frame, which keeps mode switches glitch-free.
module vga_timing_gen #(
    parameter int CW       = 11,
    parameter int H0_VIEW  = 640,
    parameter int H0_FRONT = 16,
    parameter int H0_SYNC  = 96,
    parameter int H0_BACK  = 48,
    parameter int V0_VIEW  = 480,
    parameter int V0_FRONT = 10,
    parameter int V0_SYNC  = 2,
    parameter int V0_BACK  = 33,
    parameter int H0_POL   = 0,
    parameter int V0_POL   = 0,
    parameter int H1_VIEW  = 1024,
    parameter int H1_FRONT = 24,
    parameter int H1_SYNC  = 136,
    parameter int H1_BACK  = 160,
    parameter int V1_VIEW  = 768,
    parameter int V1_FRONT = 3,
    parameter int V1_SYNC  = 6,
    parameter int V1_BACK  = 29,
    parameter int H1_POL   = 0,
    parameter int V1_POL   = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          mode,
    output logic          mode_active,
    output logic [CW-1:0] hpos,
    output logic [CW-1:0] vpos,
    output logic          hsync,
    output logic          vsync,
    output logic          hblank,
    output logic          vblank,
    output logic          visible,
    output logic          hmax,
    output logic          vmax,
    output logic [7:0]    frame
);

    localparam int H0_TOTAL = H0_VIEW + H0_FRONT + H0_SYNC + H0_BACK;
    localparam int V0_TOTAL = V0_VIEW + V0_FRONT + V0_SYNC + V0_BACK;
    localparam int H1_TOTAL = H1_VIEW + H1_FRONT + H1_SYNC + H1_BACK;
    localparam int V1_TOTAL = V1_VIEW + V1_FRONT + V1_SYNC + V1_BACK;

    // Counters must be able to hold TOTAL-1 for every timing set.
    if (H0_TOTAL > (1 << CW)) begin : g_chk_h0
        $error("vga_timing_gen: H0 total does not fit in CW bits");
    end
    if (V0_TOTAL > (1 << CW)) begin : g_chk_v0
        $error("vga_timing_gen: V0 total does not fit in CW bits");
    end
    if (H1_TOTAL > (1 << CW)) begin : g_chk_h1
        $error("vga_timing_gen: H1 total does not fit in CW bits");
    end
    if (V1_TOTAL > (1 << CW)) begin : g_chk_v1
        $error("vga_timing_gen: V1 total does not fit in CW bits");
    end

    // Per-mode decode thresholds. Sync-end is one bit wider so a zero back
    // porch (sync end == TOTAL == 2^CW) cannot wrap to zero.
    localparam logic [CW-1:0] H0_VIEW_C = CW'(H0_VIEW);
    localparam logic [CW-1:0] H0_SS_C   = CW'(H0_VIEW + H0_FRONT);
    localparam logic [CW:0]   H0_SE_C   = (CW+1)'(H0_VIEW + H0_FRONT + H0_SYNC);
    localparam logic [CW-1:0] H0_MAX_C  = CW'(H0_TOTAL - 1);
    localparam logic [CW-1:0] V0_VIEW_C = CW'(V0_VIEW);
    localparam logic [CW-1:0] V0_SS_C   = CW'(V0_VIEW + V0_FRONT);
    localparam logic [CW:0]   V0_SE_C   = (CW+1)'(V0_VIEW + V0_FRONT + V0_SYNC);
    localparam logic [CW-1:0] V0_MAX_C  = CW'(V0_TOTAL - 1);
    localparam logic [CW-1:0] H1_VIEW_C = CW'(H1_VIEW);
    localparam logic [CW-1:0] H1_SS_C   = CW'(H1_VIEW + H1_FRONT);
    localparam logic [CW:0]   H1_SE_C   = (CW+1)'(H1_VIEW + H1_FRONT + H1_SYNC);
    localparam logic [CW-1:0] H1_MAX_C  = CW'(H1_TOTAL - 1);
    localparam logic [CW-1:0] V1_VIEW_C = CW'(V1_VIEW);
    localparam logic [CW-1:0] V1_SS_C   = CW'(V1_VIEW + V1_FRONT);
    localparam logic [CW:0]   V1_SE_C   = (CW+1)'(V1_VIEW + V1_FRONT + V1_SYNC);
    localparam logic [CW-1:0] V1_MAX_C  = CW'(V1_TOTAL - 1);
    localparam logic          H0_POL_C  = (H0_POL != 0);
    localparam logic          V0_POL_C  = (V0_POL != 0);
    localparam logic          H1_POL_C  = (H1_POL != 0);
    localparam logic          V1_POL_C  = (V1_POL != 0);

    logic [CW-1:0] hpos_q, hpos_d;
    logic [CW-1:0] vpos_q, vpos_d;
    logic [7:0]    frame_q, frame_d;
    logic          mode_q, mode_d;

    logic [CW-1:0] h_view, h_ss, h_max;
    logic [CW-1:0] v_view, v_ss, v_max;
    logic [CW:0]   h_se, v_se;
    logic          h_pol, v_pol;
    logic          hmax_w, vmax_w;

    // Select the timing set currently in force.
    always_comb begin
        h_view = H0_VIEW_C;
        h_ss   = H0_SS_C;
        h_se   = H0_SE_C;
        h_max  = H0_MAX_C;
        v_view = V0_VIEW_C;
        v_ss   = V0_SS_C;
        v_se   = V0_SE_C;
        v_max  = V0_MAX_C;
        h_pol  = H0_POL_C;
        v_pol  = V0_POL_C;
        if (mode_q) begin
            h_view = H1_VIEW_C;
            h_ss   = H1_SS_C;
            h_se   = H1_SE_C;
            h_max  = H1_MAX_C;
            v_view = V1_VIEW_C;
            v_ss   = V1_SS_C;
            v_se   = V1_SE_C;
            v_max  = V1_MAX_C;
            h_pol  = H1_POL_C;
            v_pol  = V1_POL_C;
        end
    end

    // Zero-latency decodes of the current position.
    always_comb begin
        hmax_w  = (hpos_q == h_max);
        vmax_w  = (vpos_q == v_max);
        hblank  = (hpos_q >= h_view);
        vblank  = (vpos_q >= v_view);
        visible = ~hblank & ~vblank;
        hsync   = ((hpos_q >= h_ss) && ({1'b0, hpos_q} < h_se)) ? h_pol : ~h_pol;
        vsync   = ((vpos_q >= v_ss) && ({1'b0, vpos_q} < v_se)) ? v_pol : ~v_pol;
    end

    // Next position; the mode request is adopted only on the frame's last pixel.
    always_comb begin
        hpos_d  = hpos_q + 1'b1;
        vpos_d  = vpos_q;
        frame_d = frame_q;
        mode_d  = mode_q;
        if (hmax_w) begin
            hpos_d = '0;
            if (vmax_w) begin
                vpos_d  = '0;
                frame_d = frame_q + 8'd1;
                mode_d  = mode;
            end else begin
                vpos_d = vpos_q + 1'b1;
            end
        end
    end

    // State register; reset restarts the frame and resamples the mode.
    always_ff @(posedge clk) begin
        if (reset) begin
            hpos_q  <= '0;
            vpos_q  <= '0;
            frame_q <= '0;
            mode_q  <= mode;
        end else begin
            hpos_q  <= hpos_d;
            vpos_q  <= vpos_d;
            frame_q <= frame_d;
            mode_q  <= mode_d;
        end
    end

    assign hpos        = hpos_q;
    assign vpos        = vpos_q;
    assign frame       = frame_q;
    assign mode_active = mode_q;
    assign hmax        = hmax_w;
    assign vmax        = vmax_w;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen using a reduced timing set so whole frames (and a
// 256-frame wrap) fit in a short run:
//   mode 0: H 8/1/2/1 (total 12, sync 9..10, low)  V 5/1/1/1 (total 8, sync 6, low)
//   mode 1: H 12/2/3/3 (total 20, sync 14..16, high) V 6/1/2/1 (total 10, sync 7..8, low)
// Stimulus pushes expected values tagged with the clock tick they apply to;
// a monitor compares them on the falling edge of that tick.
module tb_vga_timing_gen;

    logic          clk = 1'b0;
    logic          reset;
    logic          mode;
    logic          mode_active;
    logic [4:0]    hpos;
    logic [4:0]    vpos;
    logic          hsync;
    logic          vsync;
    logic          hblank;
    logic          vblank;
    logic          visible;
    logic          hmax;
    logic          vmax;
    logic [7:0]    frame;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .CW(5),
        .H0_VIEW(8), .H0_FRONT(1), .H0_SYNC(2), .H0_BACK(1),
        .V0_VIEW(5), .V0_FRONT(1), .V0_SYNC(1), .V0_BACK(1),
        .H0_POL(0), .V0_POL(0),
        .H1_VIEW(12), .H1_FRONT(2), .H1_SYNC(3), .H1_BACK(3),
        .V1_VIEW(6), .V1_FRONT(1), .V1_SYNC(2), .V1_BACK(1),
        .H1_POL(1), .V1_POL(0)
    ) dut (
        .clk(clk), .reset(reset), .mode(mode), .mode_active(mode_active),
        .hpos(hpos), .vpos(vpos), .hsync(hsync), .vsync(vsync),
        .hblank(hblank), .vblank(vblank), .visible(visible),
        .hmax(hmax), .vmax(vmax), .frame(frame)
    );

    typedef enum int {S_HPOS, S_VPOS, S_FRAME, S_MACT, S_HSYNC, S_VSYNC,
                      S_HBLANK, S_VBLANK, S_VIS, S_HMAX, S_VMAX} sig_e;
    typedef struct {
        int   tick;
        sig_e sig;
        int   val;
    } exp_t;

    exp_t sb[$];
    int   tick = 0;
    int   checks = 0;
    int   errors = 0;
    int   max_tick = 0;
    int   base;
    int   base2;

    always @(posedge clk) tick <= tick + 1;

    function automatic logic [31:0] actual(input sig_e s);
        case (s)
            S_HPOS:   return 32'(hpos);
            S_VPOS:   return 32'(vpos);
            S_FRAME:  return 32'(frame);
            S_MACT:   return 32'(mode_active);
            S_HSYNC:  return 32'(hsync);
            S_VSYNC:  return 32'(vsync);
            S_HBLANK: return 32'(hblank);
            S_VBLANK: return 32'(vblank);
            S_VIS:    return 32'(visible);
            S_HMAX:   return 32'(hmax);
            default:  return 32'(vmax);
        endcase
    endfunction

    // Monitor: compare every expectation due at this tick; overdue ones fail.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].tick == tick) begin
                checks++;
                if (actual(sb[i].sig) !== 32'(sb[i].val)) begin
                    errors++;
                    $display("FAIL %s tick=%0d got=%0d want=%0d",
                             sb[i].sig.name(), tick, actual(sb[i].sig), sb[i].val);
                end
                sb.delete(i);
            end else if (sb[i].tick < tick) begin
                checks++;
                errors++;
                $display("FAIL %s tick=%0d never sampled (due %0d) want=%0d",
                         sb[i].sig.name(), tick, sb[i].tick, sb[i].val);
                sb.delete(i);
            end
        end
    end

    task automatic ex(input int t, input sig_e s, input int v);
        exp_t e;
        e.tick = t;
        e.sig  = s;
        e.val  = v;
        sb.push_back(e);
        if (t > max_tick) max_tick = t;
    endtask

    task automatic pos(input int t, input int hp, input int vp);
        ex(t, S_HPOS, hp);
        ex(t, S_VPOS, vp);
    endtask

    task automatic at(input int t);
        while (tick < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog tick=%0d got=timeout want=finish", tick);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        mode  = 1'b0;
        at(3);
        base = tick;
        // Reset state, mode 0
        pos(base, 0, 0);
        ex(base, S_FRAME, 0);  ex(base, S_MACT, 0);
        ex(base, S_HBLANK, 0); ex(base, S_VBLANK, 0); ex(base, S_VIS, 1);
        ex(base, S_HMAX, 0);   ex(base, S_VMAX, 0);
        ex(base, S_HSYNC, 1);  ex(base, S_VSYNC, 1);
        reset = 1'b0;

        // Mode 0 line and frame decode
        ex(base + 7, S_HPOS, 7);   ex(base + 7, S_VIS, 1);  ex(base + 7, S_HBLANK, 0);
        ex(base + 8, S_HPOS, 8);   ex(base + 8, S_HBLANK, 1); ex(base + 8, S_VIS, 0);
        ex(base + 8, S_HSYNC, 1);
        ex(base + 9, S_HSYNC, 0);
        ex(base + 10, S_HSYNC, 0);
        ex(base + 11, S_HSYNC, 1); ex(base + 11, S_HMAX, 1); ex(base + 11, S_HPOS, 11);
        pos(base + 12, 0, 1);      ex(base + 12, S_HMAX, 0);
        pos(base + 59, 11, 4);     ex(base + 59, S_VBLANK, 0);
        pos(base + 60, 0, 5);      ex(base + 60, S_VBLANK, 1); ex(base + 60, S_VIS, 0);
        ex(base + 71, S_VSYNC, 1);
        ex(base + 72, S_VPOS, 6);  ex(base + 72, S_VSYNC, 0);
        ex(base + 84, S_VPOS, 7);  ex(base + 84, S_VSYNC, 1); ex(base + 84, S_VMAX, 1);
        ex(base + 90, S_VMAX, 1);  ex(base + 90, S_HMAX, 0);
        pos(base + 95, 11, 7);     ex(base + 95, S_HMAX, 1); ex(base + 95, S_VMAX, 1);
        ex(base + 95, S_FRAME, 0);
        pos(base + 96, 0, 0);      ex(base + 96, S_FRAME, 1); ex(base + 96, S_VMAX, 0);

        // Request mode 1 mid-frame and hold it
        at(base + 120);
        mode = 1'b1;
        ex(base + 150, S_MACT, 0);
        ex(base + 191, S_MACT, 0); ex(base + 191, S_HMAX, 1); ex(base + 191, S_VMAX, 1);
        ex(base + 192, S_MACT, 1); pos(base + 192, 0, 0); ex(base + 192, S_FRAME, 2);
        ex(base + 203, S_HPOS, 11); ex(base + 203, S_VIS, 1);
        ex(base + 204, S_HBLANK, 1); ex(base + 204, S_VIS, 0);
        ex(base + 205, S_HSYNC, 0);
        ex(base + 206, S_HSYNC, 1);
        ex(base + 208, S_HSYNC, 1);
        ex(base + 209, S_HSYNC, 0);
        ex(base + 211, S_HPOS, 19); ex(base + 211, S_HMAX, 1);
        pos(base + 212, 0, 1);      ex(base + 212, S_HMAX, 0);
        ex(base + 312, S_VPOS, 6);  ex(base + 312, S_VBLANK, 1); ex(base + 312, S_VSYNC, 1);
        ex(base + 332, S_VPOS, 7);  ex(base + 332, S_VSYNC, 0);
        ex(base + 352, S_VPOS, 8);  ex(base + 352, S_VSYNC, 0);
        ex(base + 372, S_VPOS, 9);  ex(base + 372, S_VMAX, 1); ex(base + 372, S_VSYNC, 1);
        ex(base + 391, S_HMAX, 1);  ex(base + 391, S_VMAX, 1); ex(base + 391, S_FRAME, 2);
        pos(base + 392, 0, 0);      ex(base + 392, S_FRAME, 3); ex(base + 392, S_MACT, 1);

        // Back to mode 0
        at(base + 400);
        mode = 1'b0;
        pos(base + 591, 19, 9);     ex(base + 591, S_MACT, 1);
        pos(base + 592, 0, 0);      ex(base + 592, S_MACT, 0); ex(base + 592, S_FRAME, 4);

        // Short mode-1 pulse mid-frame must be ignored
        at(base + 600);
        mode = 1'b1;
        ex(base + 605, S_MACT, 0);
        at(base + 610);
        mode = 1'b0;
        pos(base + 611, 7, 1);
        pos(base + 687, 11, 7);     ex(base + 687, S_HMAX, 1); ex(base + 687, S_VMAX, 1);
        ex(base + 687, S_MACT, 0);
        pos(base + 688, 0, 0);      ex(base + 688, S_MACT, 0); ex(base + 688, S_FRAME, 5);

        // Enter mode 1, then reset mid-frame with mode 0 requested
        at(base + 700);
        mode = 1'b1;
        pos(base + 784, 0, 0);      ex(base + 784, S_MACT, 1); ex(base + 784, S_FRAME, 6);
        at(base + 894);
        pos(base + 894, 10, 5);     ex(base + 894, S_MACT, 1); ex(base + 894, S_FRAME, 6);
        ex(base + 894, S_HSYNC, 0);
        mode  = 1'b0;
        reset = 1'b1;
        pos(base + 895, 0, 0);      ex(base + 895, S_FRAME, 0); ex(base + 895, S_MACT, 0);
        ex(base + 895, S_HSYNC, 1); ex(base + 895, S_VSYNC, 1); ex(base + 895, S_VIS, 1);
        at(base + 895);
        reset = 1'b0;
        base2 = tick;

        // 256 mode-0 frames: frame counter wraps and counting carries on
        ex(base2 + 1, S_HPOS, 1);
        ex(base2 + 95, S_FRAME, 0); ex(base2 + 95, S_HMAX, 1); ex(base2 + 95, S_VMAX, 1);
        ex(base2 + 96, S_FRAME, 1);
        ex(base2 + 24479, S_FRAME, 254);
        pos(base2 + 24480, 0, 0);   ex(base2 + 24480, S_FRAME, 255);
        pos(base2 + 24575, 11, 7);  ex(base2 + 24575, S_FRAME, 255); ex(base2 + 24575, S_MACT, 0);
        pos(base2 + 24576, 0, 0);   ex(base2 + 24576, S_FRAME, 0);
        ex(base2 + 24577, S_HPOS, 1); ex(base2 + 24577, S_FRAME, 0);

        at(max_tick + 2);
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
